// File: rtl/instr_assembly_register.sv
// instr_assembly_register
// Assembles an IW-bit instruction from DW-bit beats. Beats arrive through a
// valid/ready handshake and fill lanes in order. A direct write can also place
// a beat into any lane. A consumer takes a complete instruction through
// IRValid/OutReady. Flush aborts a partial or complete instruction without
// clearing IROut.
// Optional feature: define IR_PARITY_EN to add the IPar input and a sticky
// ParErr output. IPar is the even-parity bit for I.
module instr_assembly_register #(
    parameter  int IW        = 16,
    parameter  int DW        = 8,
    parameter  int MSB_FIRST = 1,
    localparam int NB        = IW / DW,
    localparam int LW        = (NB > 1) ? $clog2(NB) : 1,
    localparam int CW        = $clog2(NB) + 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] I,
    input  logic          InValid,
    output logic          InReady,
    input  logic          Write,
    input  logic [LW-1:0] Lane,
    input  logic          Flush,
    input  logic          OutReady,
    output logic [IW-1:0] IROut,
    output logic          IRValid,
    output logic [CW-1:0] BeatCnt
`ifdef IR_PARITY_EN
    ,
    input  logic          IPar,
    output logic          ParErr
`endif
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] base_cnt;
    logic [LW-1:0] beat_lane;
    logic          accept;
    logic [IW-1:0] ir_next;

    // A beat accepted while FULL starts the next instruction, so its
    // position is counted from zero. This avoids a bubble.
    assign InReady   = !Write && !Flush && (state != FULL || OutReady);
    assign accept    = InValid && InReady;
    assign IRValid   = (state == FULL);
    assign base_cnt  = (state == FULL) ? '0 : BeatCnt;
    assign beat_lane = (MSB_FIRST != 0) ? (LW'(NB - 1) - base_cnt[LW-1:0])
                                        : base_cnt[LW-1:0];

    // State and beat count register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= EMPTY;
            BeatCnt <= '0;
        end else begin
            state   <= state_d;
            BeatCnt <= cnt_d;
        end
    end

    // Next state: Flush, then beat acceptance, then consumer handoff
    always_comb begin
        state_d = state;
        cnt_d   = BeatCnt;
        if (Flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            if (base_cnt == CW'(NB - 1)) begin
                state_d = FULL;
                cnt_d   = CW'(NB);
            end else begin
                state_d = FILLING;
                cnt_d   = base_cnt + 1'b1;
            end
        end else if (state == FULL && OutReady) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end
    end

    // Lane update: a direct write or an accepted beat (never both, since
    // Write blocks InReady). Lane values with no matching k are ignored.
    always_comb begin
        ir_next = IROut;
        for (int k = 0; k < NB; k++) begin
            if ((Write && Lane == LW'(k)) || (accept && beat_lane == LW'(k)))
                ir_next[k*DW +: DW] = I;
        end
    end

    // Instruction register; only reset, writes and beats change it
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            IROut <= '0;
        else
            IROut <= ir_next;
    end

`ifdef IR_PARITY_EN
    // Sticky parity error on any beat or write that is taken; Flush clears it
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            ParErr <= 1'b0;
        else if (Flush)
            ParErr <= 1'b0;
        else if ((accept || Write) && (^{I, IPar}))
            ParErr <= 1'b1;
    end
`endif

endmodule

// File: doc/instr_assembly_register.md
INSTR_ASSEMBLY_REGISTER -- requirements
Module: instr_assembly_register

Interface
REQ-001 Parameter IW, default 16: instruction width in bits; SHALL be a multiple of DW, with IW/DW (NB) >= 1.
REQ-002 Parameter DW, default 8: input bus width in bits.
REQ-003 Parameter MSB_FIRST, default 1: in sequential mode, 1 = first beat fills the top lane, 0 = first beat fills lane 0.
REQ-004 Clock  in  1  single clock; all state changes on posedge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 I  in  DW  data byte/beat.
REQ-007 InValid  in  1  sequential beat offered.
REQ-008 InReady  out  1  sequential beat accepted when InValid && InReady.
REQ-009 Write  in  1  direct lane write enable.
REQ-010 Lane  in  max(1,clog2(NB))  lane index for a direct write; lane k = IROut[k*DW +: DW].
REQ-011 Flush  in  1  synchronous abort of a partial or complete instruction.
REQ-012 OutReady  in  1  consumer takes the instruction when IRValid && OutReady.
REQ-013 IROut  out  IW  assembled instruction register.
REQ-014 IRValid  out  1  complete instruction held.
REQ-015 BeatCnt  out  clog2(NB)+1  beats accepted for the current instruction.

Function
REQ-016 FSM states: EMPTY, FILLING, FULL. IRValid SHALL be 1 only in FULL.
REQ-017 InReady = !Write && !Flush && (state != FULL || OutReady); combinational, with no dependence on InValid.
REQ-018 Accepted beat: lane = BeatCnt when MSB_FIRST = 0, NB-1-BeatCnt when MSB_FIRST = 1; write I into that lane and increment BeatCnt.
REQ-019 Accepting beat NB-1: go to FULL, and BeatCnt SHALL hold NB.
REQ-020 EMPTY -> FILLING on the first accepted beat when NB > 1; EMPTY -> FULL directly when NB = 1.
REQ-021 FULL with OutReady and no accepted beat: go to EMPTY with BeatCnt = 0. IROut SHALL be retained.
REQ-022 FULL with OutReady and an accepted beat in the same cycle: the beat is the first beat of the next instruction; BeatCnt = 1; state FILLING (or FULL when NB = 1). There SHALL be no bubble.
REQ-023 Write: IROut lane Lane <= I in every state; state and BeatCnt unchanged; Lane >= NB SHALL be ignored.
REQ-024 Write and InValid together: the direct write wins and the sequential beat is not accepted (REQ-017).
REQ-025 Flush: state -> EMPTY, BeatCnt -> 0, IRValid -> 0, IROut retained. Flush SHALL take priority over every other input except Write, whose lane write still occurs.
REQ-026 Beat-to-IRValid latency: IRValid SHALL rise one cycle after the accepting edge of the last beat.
REQ-027 No input combination SHALL change IROut except Write or an accepted beat.

Reset
REQ-028 On Reset = 0, asynchronously: IROut = 0, state = EMPTY, BeatCnt = 0, IRValid = 0; ParErr = 0 when present.
REQ-029 Reset during FILLING or FULL SHALL discard partial and complete instructions.
REQ-030 After release, InReady = 1 in the first cycle (absent Write/Flush).

Configuration
REQ-031 With macro IR_PARITY_EN defined: add input IPar (1 bit, even parity over I) and output ParErr (1 bit).
REQ-032 With IR_PARITY_EN: ParErr is sticky, set when an accepted beat or a direct write has ^{I,IPar} = 1; cleared by Flush or Reset.
REQ-033 Without IR_PARITY_EN: IPar and ParErr do not exist and no parity logic is built.

Verification (IW=16, DW=8, MSB_FIRST=1 unless stated)
REQ-034 Beats 0xAB then 0xCD with InValid=1, OutReady=0 -> IROut = 0xABCD, IRValid = 1 one cycle later, BeatCnt = 2, InReady = 0.
REQ-035 FULL with 0xABCD; OutReady=1, InValid=1, I=0x12 same cycle -> IRValid = 0, BeatCnt = 1, IROut = 0x12CD, state FILLING.
REQ-036 Write=1, Lane=0, I=0x55 while InValid=1 -> IROut[7:0] = 0x55, beat not accepted, BeatCnt unchanged.
REQ-037 After beat 0x77, Flush=1 -> BeatCnt = 0, IRValid = 0, IROut[15:8] = 0x77 retained; next beat 0x88 lands in [15:8].
REQ-038 Reset asserted low mid-FILLING, no clock edge -> IROut = 0x0000, BeatCnt = 0 immediately.
REQ-039 IW=32, MSB_FIRST=0, beats 0x01,0x02,0x03,0x04 -> IROut = 0x04030201; with IR_PARITY_EN, IPar=0 on 0x01 -> ParErr = 1 until Flush.
